// File: rtl/instr_fetch.sv
// Fetch stage: holds the PC, fetches over a req/ack handshake, latches the instruction, selects the next PC.
// Optional macro FETCH_JUMP_EN adds the j (opcode 6'b000010) target path.
module instr_fetch #(
    parameter logic [31:0] RESET_PC       = 32'h0000_0000,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        branch,
    input  logic        zero,
    output logic [31:0] instr,
    output logic [5:0]  opcode,
    output logic        instr_valid,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        fetch_fault
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_EXEC,
        S_FAULT
    } state_t;

    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t      r_state, w_state_next;
    logic [31:0] r_pc, w_pc_next;
    logic [31:0] r_instr, w_instr_next;
    logic        r_instr_valid, w_instr_valid_next;
    logic        r_fault, w_fault_next;
    logic [15:0] r_wait_cnt, w_wait_cnt_next;
    logic        w_req;

    logic [31:0] w_pc_plus4;
    logic [31:0] w_branch_target;
    logic [31:0] w_seq_target;

    assign w_pc_plus4      = r_pc + 32'd4;
    assign w_branch_target = w_pc_plus4 + {{14{r_instr[15]}}, r_instr[15:0], 2'b00};

`ifdef FETCH_JUMP_EN
    logic        w_is_jump;
    logic [31:0] w_jump_target;

    assign w_is_jump     = (r_instr[31:26] == 6'b000010);
    assign w_jump_target = {w_pc_plus4[31:28], r_instr[25:0], 2'b00};
    // Jump outranks branch.
    assign w_seq_target  = w_is_jump       ? w_jump_target   :
                           (branch & zero) ? w_branch_target : w_pc_plus4;
`else
    assign w_seq_target  = (branch & zero) ? w_branch_target : w_pc_plus4;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= S_IDLE;
            r_pc          <= RESET_PC;
            r_instr       <= 32'h0;
            r_instr_valid <= 1'b0;
            r_fault       <= 1'b0;
            r_wait_cnt    <= 16'h0;
        end else begin
            r_state       <= w_state_next;
            r_pc          <= w_pc_next;
            r_instr       <= w_instr_next;
            r_instr_valid <= w_instr_valid_next;
            r_fault       <= w_fault_next;
            r_wait_cnt    <= w_wait_cnt_next;
        end
    end

    always_comb begin
        w_state_next       = r_state;
        w_pc_next          = r_pc;
        w_instr_next       = r_instr;
        w_instr_valid_next = r_instr_valid;
        w_fault_next       = r_fault;
        w_wait_cnt_next    = r_wait_cnt;
        w_req              = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_state_next = S_FETCH;
            end
            S_FETCH: begin
                w_req = 1'b1;
                if (imem_ack) begin
                    w_instr_next       = imem_rdata;
                    w_instr_valid_next = 1'b1;
                    w_wait_cnt_next    = 16'h0;
                    w_state_next       = S_EXEC;
                end else if (r_wait_cnt == TIMEOUT_LAST) begin
                    w_fault_next = 1'b1;
                    w_state_next = S_FAULT;
                end else begin
                    w_wait_cnt_next = r_wait_cnt + 16'd1;
                end
            end
            S_EXEC: begin
                if (!stall) begin
                    w_pc_next          = w_seq_target;
                    w_instr_valid_next = 1'b0;
                    w_state_next       = S_FETCH;
                end
            end
            S_FAULT: begin
                w_instr_valid_next = 1'b0;
                w_fault_next       = 1'b1;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Request is decoded from state so an async reset withdraws it at once.
    assign imem_req    = w_req;
    assign imem_addr   = r_pc;
    assign instr       = r_instr;
    assign opcode      = r_instr[31:26];
    assign instr_valid = r_instr_valid;
    assign pc          = r_pc;
    assign pc_plus4    = w_pc_plus4;
    assign fetch_fault = r_fault;

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Fetch stage of the MIPS single-cycle core. It holds the PC, requests instructions from instruction memory over a req/ack handshake, and latches the returned word.
- Drives `opcode` into the main control decoder.
- Takes the decoder's `branch` and the ALU's `zero` back in to select the next PC.
- A two-state execute/fetch sequence gives one instruction in flight at a time; a watchdog flags a hung memory.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- TIMEOUT_CYCLES, 255, number of consecutive un-acked request cycles before a fetch fault (range 1..65535).

Ports:
- clk  input  1  core clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- imem_req  output  1  fetch request to instruction memory.
- imem_addr  output  32  fetch address; equals pc while imem_req=1.
- imem_ack  input  1  memory has `imem_rdata` valid this cycle.
- imem_rdata  input  32  instruction word from memory.
- stall  input  1  downstream hold; freezes the execute cycle.
- branch  input  1  branch control from the control decoder.
- zero  input  1  ALU zero flag.
- instr  output  32  latched instruction.
- opcode  output  6  instr[31:26], feeds the control decoder.
- instr_valid  output  1  `instr` is the current executing instruction.
- pc  output  32  address of the current instruction.
- pc_plus4  output  32  pc + 4, combinational.
- fetch_fault  output  1  sticky watchdog error.

Behaviour:
- Reset (reset_n=0, asynchronous):
  - pc=RESET_PC, state=IDLE, instr=32'h0, instr_valid=0, imem_req=0, fetch_fault=0, wait counter=0.
  - An outstanding request is dropped immediately.
- States:
  - IDLE: imem_req=0. Moves to FETCH on the first clock edge after reset release.
  - FETCH:
    - imem_req=1, imem_addr=pc.
    - On a cycle with imem_ack=1: instr<=imem_rdata, instr_valid<=1, counter<=0, next state EXEC.
    - Ack in the very first FETCH cycle is accepted (zero-wait memory).
    - Each cycle without ack: counter+1. When counter reaches TIMEOUT_CYCLES-1 with no ack: next state FAULT, fetch_fault<=1.
  - EXEC:
    - imem_req=0, instr_valid=1. The decoder and ALU evaluate combinationally; branch and zero are sampled here.
    - If stall=1: remain in EXEC; pc, instr and instr_valid are held.
    - If stall=0: update pc (rules below), instr_valid<=0, next state FETCH.
  - FAULT: imem_req=0, instr_valid=0, fetch_fault=1. Exited only by reset.
- Next-PC rules:
  - Taken branch (branch & zero): pc <= pc_plus4 + (sign_extend(instr[15:0]) << 2).
  - Otherwise: pc <= pc_plus4.
  - All PC arithmetic is 32-bit modulo 2^32; wrap-around is silent. pc=32'hFFFF_FFFC goes to 32'h0000_0000.
- Input qualification:
  - branch and zero are ignored outside EXEC.
  - imem_ack is ignored outside FETCH.
  - stall is ignored outside EXEC.
- Outputs `instr` and `opcode`:
  - `instr` holds its last value while instr_valid=0.
  - `opcode` is always instr[31:26]. After reset it is 6'b000000, so the decoder sees an R-type pattern; consumers qualify with instr_valid.
- Throughput: minimum 2 cycles per instruction (1 FETCH + 1 EXEC) with zero-wait memory.
- Reset mid-FETCH or mid-EXEC returns to the reset state; no partial PC update survives.

Optional Feature:
- Macro: FETCH_JUMP_EN.
- Defined: opcode 6'b000010 (j) in EXEC with stall=0 sets pc <= {pc_plus4[31:28], instr[25:0], 2'b00}. Jump takes priority over branch.
- Undefined: opcode 6'b000010 is handled as any non-branch instruction (pc <= pc_plus4). No extra logic is instantiated.

Test Plan:
- Reset/boot:
  - Stimulus: assert reset_n=0 mid-FETCH, release; memory acks after 2 wait cycles with 32'h8C010004.
  - Required: imem_req drops immediately on reset. After release, imem_addr=0, opcode=6'b100011, instr_valid=1 for 1 cycle, then imem_addr=4.
- Sequential fetch:
  - Stimulus: zero-wait memory, 4 non-branch words.
  - Required: addresses 0, 4, 8, 12 on consecutive FETCH cycles; instr_valid alternates 0/1 every cycle.
- Taken branch, negative offset:
  - Stimulus: pc=32'h20, instr=32'h1000FFFE, branch=1, zero=1.
  - Required: next pc=32'h1C.
  - Same with zero=0: next pc=32'h24.
- Stall:
  - Stimulus: stall=1 for 3 EXEC cycles.
  - Required: pc, instr and instr_valid=1 held; imem_req=0; fetch resumes at pc+4 on the cycle after stall drops.
- Timeout:
  - Stimulus: TIMEOUT_CYCLES=4, never ack.
  - Required: imem_req high 4 cycles, then fetch_fault=1 and imem_req=0 permanently until reset_n=0.
- Jump (FETCH_JUMP_EN):
  - Stimulus: pc=32'h40, instr=32'h08000100.
  - Required: next pc=32'h400 with the macro defined; 32'h44 without it.
